// File: rtl/procyon_mul_fu.sv
// Iterative radix-2 shift-add multiply unit (MUL/MULH/MULHSU/MULHU) fed by a reservation station.
// One operation takes OPTN_DATA_WIDTH busy cycles; the result is broadcast as a one-cycle CDB pulse.
module procyon_mul_fu #(
    parameter int unsigned OPTN_DATA_WIDTH    = 32,
    parameter int unsigned OPTN_ROB_IDX_WIDTH = 5,
    parameter int unsigned PCYN_OP_WIDTH      = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_flush,
    input  logic                                i_fu_valid,
    input  logic [PCYN_OP_WIDTH-1:0]            i_fu_op,
    input  logic [1:0][OPTN_DATA_WIDTH-1:0]     i_fu_src,
    input  logic [OPTN_ROB_IDX_WIDTH-1:0]       i_fu_tag,
    output logic                                o_fu_stall,
    output logic                                o_cdb_en,
    output logic [OPTN_DATA_WIDTH-1:0]          o_cdb_data,
    output logic [OPTN_ROB_IDX_WIDTH-1:0]       o_cdb_tag
);

    localparam int unsigned W    = OPTN_DATA_WIDTH;
    localparam int unsigned CntW = $clog2(W);

    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_MUL    = PCYN_OP_WIDTH'(20);
    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_MULH   = PCYN_OP_WIDTH'(21);
    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_MULHSU = PCYN_OP_WIDTH'(22);
    localparam logic [PCYN_OP_WIDTH-1:0] PCYN_OP_MULHU  = PCYN_OP_WIDTH'(23);

    localparam logic [W-1:0]    OneW    = W'(1);
    localparam logic [2*W-1:0]  One2W   = (2*W)'(1);
    localparam logic [CntW-1:0] OneCnt  = CntW'(1);
    localparam logic [CntW-1:0] LastCnt = CntW'(W - 1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                          state_q, state_d;
    logic [CntW-1:0]                 cnt_q, cnt_d;
    logic [W-1:0]                    mcand_q, mcand_d;
    logic [W-1:0]                    mplier_q, mplier_d;
    logic [2*W-1:0]                  acc_q, acc_d;
    logic                            neg_q, neg_d;
    logic                            hi_q, hi_d;
    logic [OPTN_ROB_IDX_WIDTH-1:0]   tag_q, tag_d;
    logic                            cdb_en_q, cdb_en_d;
    logic [W-1:0]                    cdb_data_q, cdb_data_d;
    logic [OPTN_ROB_IDX_WIDTH-1:0]   cdb_tag_q, cdb_tag_d;

    logic                            rs1_signed, rs2_signed, op_hi;
    logic                            rs1_neg, rs2_neg;
    logic [W-1:0]                    rs1_mag, rs2_mag;
    logic [2*W-1:0]                  addend, acc_sum, product;

    // Operand interpretation; unknown opcodes fall back to MUL.
    always_comb begin
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        op_hi      = 1'b0;
        case (i_fu_op)
            PCYN_OP_MULH: begin
                rs1_signed = 1'b1;
                rs2_signed = 1'b1;
                op_hi      = 1'b1;
            end
            PCYN_OP_MULHSU: begin
                rs1_signed = 1'b1;
                op_hi      = 1'b1;
            end
            PCYN_OP_MULHU: op_hi = 1'b1;
            PCYN_OP_MUL:   op_hi = 1'b0;
            default:       op_hi = 1'b0;
        endcase

        rs1_neg = rs1_signed & i_fu_src[0][W-1];
        rs2_neg = rs2_signed & i_fu_src[1][W-1];
        rs1_mag = rs1_neg ? (~i_fu_src[0] + OneW) : i_fu_src[0];
        rs2_mag = rs2_neg ? (~i_fu_src[1] + OneW) : i_fu_src[1];
    end

    always_comb begin
        addend  = mplier_q[0] ? ({{W{1'b0}}, mcand_q} << cnt_q) : '0;
        acc_sum = acc_q + addend;
        product = neg_q ? (~acc_sum + One2W) : acc_sum;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        acc_d      = acc_q;
        neg_d      = neg_q;
        hi_d       = hi_q;
        tag_d      = tag_q;
        cdb_en_d   = 1'b0;
        cdb_data_d = cdb_data_q;
        cdb_tag_d  = cdb_tag_q;

        if (i_flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (i_fu_valid) begin
                        state_d  = StBusy;
                        cnt_d    = '0;
                        mcand_d  = rs1_mag;
                        mplier_d = rs2_mag;
                        acc_d    = '0;
                        neg_d    = rs1_neg ^ rs2_neg;
                        hi_d     = op_hi;
                        tag_d    = i_fu_tag;
                    end
                end
                StBusy: begin
                    acc_d    = acc_sum;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + OneCnt;
                    if (cnt_q == LastCnt) begin
                        state_d    = StIdle;
                        cnt_d      = '0;
                        cdb_en_d   = 1'b1;
                        cdb_data_d = hi_q ? product[2*W-1:W] : product[W-1:0];
                        cdb_tag_d  = tag_q;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            neg_q      <= 1'b0;
            hi_q       <= 1'b0;
            tag_q      <= '0;
            cdb_en_q   <= 1'b0;
            cdb_data_q <= '0;
            cdb_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            acc_q      <= acc_d;
            neg_q      <= neg_d;
            hi_q       <= hi_d;
            tag_q      <= tag_d;
            cdb_en_q   <= cdb_en_d;
            cdb_data_q <= cdb_data_d;
            cdb_tag_q  <= cdb_tag_d;
        end
    end

    assign o_fu_stall = (state_q == StBusy);
    assign o_cdb_en   = cdb_en_q;
    assign o_cdb_data = cdb_data_q;
    assign o_cdb_tag  = cdb_tag_q;

endmodule

// File: tb/tb_procyon_mul_fu.sv
// Directed bench for procyon_mul_fu: latency, signedness variants, back-to-back issue, flush, reset.
module tb_procyon_mul_fu;

    localparam int unsigned W  = 32;
    localparam int unsigned TW = 5;

    localparam logic [5:0] OP_MUL    = 6'd20;
    localparam logic [5:0] OP_MULH   = 6'd21;
    localparam logic [5:0] OP_MULHSU = 6'd22;
    localparam logic [5:0] OP_MULHU  = 6'd23;

    logic              clk;
    logic              rst;
    logic              flush;
    logic              fu_valid;
    logic [5:0]        fu_op;
    logic [1:0][W-1:0] fu_src;
    logic [TW-1:0]     fu_tag;
    logic              fu_stall;
    logic              cdb_en;
    logic [W-1:0]      cdb_data;
    logic [TW-1:0]     cdb_tag;

    int checks = 0;
    int errors = 0;

    procyon_mul_fu #(
        .OPTN_DATA_WIDTH   (W),
        .OPTN_ROB_IDX_WIDTH(TW),
        .PCYN_OP_WIDTH     (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (flush),
        .i_fu_valid(fu_valid),
        .i_fu_op   (fu_op),
        .i_fu_src  (fu_src),
        .i_fu_tag  (fu_tag),
        .o_fu_stall(fu_stall),
        .o_cdb_en  (cdb_en),
        .o_cdb_data(cdb_data),
        .o_cdb_tag (cdb_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [TW-1:0] tag);
        fu_valid  = 1'b1;
        fu_op     = op;
        fu_src[0] = a;
        fu_src[1] = b;
        fu_tag    = tag;
    endtask

    // Full op from accept to the cycle after its broadcast, checking every cycle.
    task automatic run_op(input string name, input logic [5:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [TW-1:0] tag,
                          input logic [W-1:0] exp);
        issue(op, a, b, tag);
        tick();
        fu_valid = 1'b0;
        check({name, " stall@k"}, 64'(fu_stall), 64'd1);
        check({name, " en@k"}, 64'(cdb_en), 64'd0);
        for (int i = 1; i < int'(W); i++) begin
            tick();
            check({name, " stall busy"}, 64'(fu_stall), 64'd1);
            check({name, " en busy"}, 64'(cdb_en), 64'd0);
        end
        tick();
        check({name, " en@k+W"}, 64'(cdb_en), 64'd1);
        check({name, " data"}, 64'(cdb_data), 64'(exp));
        check({name, " tag"}, 64'(cdb_tag), 64'(tag));
        check({name, " stall@k+W"}, 64'(fu_stall), 64'd0);
        tick();
        check({name, " en cleared"}, 64'(cdb_en), 64'd0);
        check({name, " data hold"}, 64'(cdb_data), 64'(exp));
    endtask

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        fu_valid = 1'b0;
        fu_op    = OP_MUL;
        fu_src   = '0;
        fu_tag   = '0;
        #12;
        check("reset stall", 64'(fu_stall), 64'd0);
        check("reset en", 64'(cdb_en), 64'd0);
        check("reset data", 64'(cdb_data), 64'd0);
        check("reset tag", 64'(cdb_tag), 64'd0);
        rst = 1'b0;

        run_op("mul7x6", OP_MUL, 32'd7, 32'd6, 5'd3, 32'd42);

        run_op("mulh -1*-1", OP_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd8, 32'h00000000);
        run_op("mul -1*-1", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9, 32'h00000001);
        run_op("mulhu max*max", OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'hFFFFFFFE);

        run_op("mulhsu -1*max", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 32'hFFFFFFFF);
        run_op("mulh min*-1", OP_MULH, 32'h80000000, 32'hFFFFFFFF, 5'd12, 32'h00000000);
        run_op("mul min*-1", OP_MUL, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000);
        run_op("mulh -3*5", OP_MULH, 32'hFFFFFFFD, 32'd5, 5'd14, 32'hFFFFFFFF);
        run_op("bad op as mul", 6'd0, 32'd1000, 32'd1000, 5'd15, 32'd1000000);

        // Back-to-back: valid held, RS presents the second op during the stall.
        issue(OP_MUL, 32'd3, 32'd5, 5'd1);
        tick();
        issue(OP_MULHU, 32'hFFFFFFFF, 32'd2, 5'd2);
        for (int i = 1; i < int'(W); i++) begin
            tick();
            check("b2b stall A", 64'(fu_stall), 64'd1);
            check("b2b en A", 64'(cdb_en), 64'd0);
        end
        tick();
        check("b2b en k+32", 64'(cdb_en), 64'd1);
        check("b2b data A", 64'(cdb_data), 64'd15);
        check("b2b tag A", 64'(cdb_tag), 64'd1);
        check("b2b idle k+32", 64'(fu_stall), 64'd0);
        tick();
        fu_valid = 1'b0;
        check("b2b accept k+33", 64'(fu_stall), 64'd1);
        check("b2b en k+33", 64'(cdb_en), 64'd0);
        for (int i = 1; i < int'(W); i++) begin
            tick();
            check("b2b en B", 64'(cdb_en), 64'd0);
        end
        tick();
        check("b2b en k+65", 64'(cdb_en), 64'd1);
        check("b2b data B", 64'(cdb_data), 64'd1);
        check("b2b tag B", 64'(cdb_tag), 64'd2);
        tick();

        // Flush mid-op, then a fresh op on the next edge.
        issue(OP_MUL, 32'd9, 32'd9, 5'd4);
        tick();
        fu_valid = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush stall", 64'(fu_stall), 64'd0);
        check("flush en", 64'(cdb_en), 64'd0);
        issue(OP_MUL, 32'd10, 32'd10, 5'd5);
        tick();
        fu_valid = 1'b0;
        check("post-flush accept", 64'(fu_stall), 64'd1);
        for (int i = 12; i < 43; i++) begin
            tick();
            check("post-flush no pulse", 64'(cdb_en), 64'd0);
        end
        tick();
        check("post-flush en k+43", 64'(cdb_en), 64'd1);
        check("post-flush data", 64'(cdb_data), 64'd100);
        check("post-flush tag", 64'(cdb_tag), 64'd5);
        tick();

        // Flush on the completing edge suppresses the broadcast.
        issue(OP_MUL, 32'd11, 32'd11, 5'd6);
        tick();
        fu_valid = 1'b0;
        for (int i = 1; i < int'(W); i++) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush@done en", 64'(cdb_en), 64'd0);
        check("flush@done stall", 64'(fu_stall), 64'd0);
        check("flush@done data hold", 64'(cdb_data), 64'd100);
        check("flush@done tag hold", 64'(cdb_tag), 64'd5);
        tick();
        check("flush@done en later", 64'(cdb_en), 64'd0);

        // Asynchronous reset mid-op.
        issue(OP_MUL, 32'd2, 32'd2, 5'd7);
        tick();
        fu_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        #2 rst = 1'b1;
        #1;
        check("async rst stall", 64'(fu_stall), 64'd0);
        check("async rst en", 64'(cdb_en), 64'd0);
        check("async rst data", 64'(cdb_data), 64'd0);
        check("async rst tag", 64'(cdb_tag), 64'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            check("post-rst no pulse", 64'(cdb_en), 64'd0);
        end
        check("post-rst idle", 64'(fu_stall), 64'd0);

        run_op("after rst", OP_MULHU, 32'h80000000, 32'd4, 5'd31, 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
